// File: rtl/uart_pkg.sv
// UART shared definitions: frame defaults and receiver state encoding.
// Used by both the transmitter and the receiver on the same link.
package uart_pkg;

  localparam int DEF_WORD_SIZE   = 8;
  localparam int DEF_PULSE_WIDTH = 4;
  localparam int DEF_PACKET_SIZE = DEF_WORD_SIZE + 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side word handshake: valid/ready data plus error strobes.
// The receiver is the master; the consumer is the slave.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
);

  logic [WORD_SIZE-1:0] data_bits;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_bits,
    output data_valid,
    input  data_ready,
    output frame_err,
    output overrun
  );

  modport slave (
    input  data_bits,
    input  data_valid,
    output data_ready,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Reset value is a parameter so idle-high lines start idle.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: mid-bit sampling, LSB-first assembly,
// valid/ready delivery with framing-error and overrun strobes.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int PACKET_SIZE = DEF_PACKET_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  uart_receiver_if.master bus
);

  localparam int CW   = $clog2(PULSE_WIDTH);
  localparam int BW   = $clog2(WORD_SIZE + 1);
  localparam int HALF = PULSE_WIDTH / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(PULSE_WIDTH - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(WORD_SIZE - 1);

  if (PULSE_WIDTH < 2) begin : g_bad_pulse
    $error("PULSE_WIDTH must be at least 2");
  end
  if (PACKET_SIZE != WORD_SIZE + 2) begin : g_bad_packet
    $error("PACKET_SIZE must equal WORD_SIZE+2");
  end

  rx_state_t            state_q;
  rx_state_t            state_d;
  logic [CW-1:0]        clk_cnt;
  logic [CW-1:0]        clk_d;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_d;
  logic [WORD_SIZE-1:0] shift_q;
  logic [WORD_SIZE-1:0] shift_d;
  logic                 done;
  logic                 ferr;
  logic                 rx_s;

  uart_rx_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .raw (rx),
    .sync(rx_s)
  );

  always_comb begin
    state_d = state_q;
    clk_d   = clk_cnt;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    done    = 1'b0;
    ferr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          clk_d   = '0;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          clk_d = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_d   = '0;
          bit_d   = bit_cnt + 1'b1;
          shift_d = {rx_s, shift_q[WORD_SIZE-1:1]};
          if (bit_cnt == WORD_LAST) begin
            state_d = STOP;
          end
        end else begin
          clk_d = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_d = '0;
          if (rx_s) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          clk_d = clk_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      clk_cnt        <= '0;
      bit_cnt        <= '0;
      shift_q        <= '0;
      bus.data_bits  <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_cnt       <= clk_d;
      bit_cnt       <= bit_d;
      shift_q       <= shift_d;
      bus.frame_err <= ferr;
      bus.overrun   <= 1'b0;
      // a completed word replaces the held one only if it is being taken
      if (done) begin
        if (!bus.data_valid || bus.data_ready) begin
          bus.data_bits  <= shift_q;
          bus.data_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scoreboard of expected
// words popped on each accepted handshake, plus flag counters.
module tb_uart_receiver;

  localparam int W  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int ov_cyc = -1;
  int fe_cyc = -1;
  int vcyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic valid_q = 1'b0;
  logic [W-1:0] exp_q[$];

  uart_receiver_if #(.WORD_SIZE(W)) bus ();

  uart_receiver #(
    .WORD_SIZE  (W),
    .PULSE_WIDTH(PW),
    .PACKET_SIZE(W + 2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_valid) vcyc++;
      if (bus.data_valid && !valid_q) rise_cyc = cyc;
      valid_q = bus.data_valid;
      if (bus.frame_err) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (bus.overrun) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
      if (bus.data_valid && bus.data_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 1, 0);
        else check("word", bus.data_bits, exp_q.pop_front());
      end
    end else begin
      valid_q = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(PW);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop_b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(w[i]);
    drive_bit(stop_b);
  endtask

  task automatic clear_counts();
    vcyc   = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    rise_cyc = -1;
    ov_cyc = -1;
    fe_cyc = -1;
  endtask

  int s2;
  logic bad;

  initial begin
    bus.data_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_valid", bus.data_valid, 0);
    check("rst_bits", bus.data_bits, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    tick(5);

    // single frame, consumer always ready
    clear_counts();
    bus.data_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(6);
    check("a5_latency", rise_cyc, start_cyc + 1 + 40);
    check("a5_valid_cycles", vcyc, 1);
    check("a5_ferr", fe_cnt, 0);
    check("a5_ovr", ov_cnt, 0);

    // back-to-back frames with consumer stalled
    clear_counts();
    bus.data_ready = 1'b0;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    s2 = cyc;
    send_frame(8'hFF, 1'b1);
    tick(6);
    check("b2b_bits", bus.data_bits, 8'h00);
    check("b2b_valid", bus.data_valid, 1);
    check("b2b_ovr_cnt", ov_cnt, 1);
    check("b2b_ovr_time", ov_cyc, s2 + 1 + 40);
    check("b2b_ferr", fe_cnt, 0);
    bus.data_ready = 1'b1;
    tick(3);
    check("b2b_drained", bus.data_valid, 0);
    check("b2b_queue", exp_q.size(), 0);

    // framing error followed by a held-low line
    clear_counts();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(10);
    check("fe_cnt", fe_cnt, 1);
    check("fe_time", fe_cyc, start_cyc + 1 + 40);
    check("fe_no_word", vcyc, 0);
    check("fe_ovr", ov_cnt, 0);
    clear_counts();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(6);
    check("after_fe_valid_cycles", vcyc, 1);
    check("after_fe_ferr", fe_cnt, 0);
    check("after_fe_queue", exp_q.size(), 0);

    // one-cycle glitch while idle
    clear_counts();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(30);
    check("glitch_valid", vcyc, 0);
    check("glitch_ferr", fe_cnt, 0);
    check("glitch_ovr", ov_cnt, 0);

    // reset during data bit 4 of 0x81
    clear_counts();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx = 1'b1;
    check("midrst_bits", bus.data_bits, 0);
    check("midrst_valid", bus.data_valid, 0);
    check("midrst_ferr", bus.frame_err, 0);
    check("midrst_ovr", bus.overrun, 0);
    tick(60);
    check("midrst_no_word", vcyc, 0);
    check("midrst_no_fe", fe_cnt, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    tick(6);
    check("7e_valid_cycles", vcyc, 1);
    check("7e_queue", exp_q.size(), 0);

    // long stall then accept
    clear_counts();
    bus.data_ready = 1'b0;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    tick(3);
    check("hold_valid", bus.data_valid, 1);
    check("hold_bits", bus.data_bits, 8'hC3);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.data_bits !== 8'hC3 || bus.data_valid !== 1'b1)
        bad = 1'b1;
    end
    check("hold_stable", bad, 0);
    bus.data_ready = 1'b1;
    tick(1);
    check("hold_cleared", bus.data_valid, 0);
    check("hold_ovr", ov_cnt, 0);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
